ij_index_sequencer: RTL

- Generates the (i, j) lane-coordinate stream that drives the 3-bit select input of the downstream i/j remap mux (mod-5 successor map) in the 5x5 lane datapath.
- Walks all 25 lanes per round, for ROUNDS rounds, using a valid/ready handshake.
- Emits a linear lane address and round/last flags for the state memory and controller.

---
 rtl/ij_index_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ij_index_sequencer.sv
// ij_index_sequencer: walks the 5x5 lane grid (i fastest) for ROUNDS rounds
// and hands each (i, j) coordinate downstream over a valid/ready handshake.
module ij_index_sequencer #(
    parameter int SIZE   = 3,
    parameter int ROUNDS = 24,
    parameter int RW     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ready,
    output logic [SIZE-1:0] i_idx,
    output logic [SIZE-1:0] j_idx,
    output logic [4:0]      lane_addr,
    output logic [RW-1:0]   round_idx,
    output logic            valid,
    output logic            last_lane,
    output logic            last_round,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] EDGE_IDX  = SIZE'(4);
    localparam logic [4:0]      LAST_ADDR = 5'd24;
    localparam logic [RW-1:0]   LAST_RND  = RW'(ROUNDS - 1);

    state_t          state, state_n;
    logic [SIZE-1:0] i_n, j_n;
    logic [4:0]      lane_n;
    logic [RW-1:0]   round_n;
    logic            valid_n, busy_n, done_n;

    // Next-state and next-output decode; a transfer is valid & ready in RUN.
    always_comb begin
        state_n = state;
        i_n     = i_idx;
        j_n     = j_idx;
        lane_n  = lane_addr;
        round_n = round_idx;
        valid_n = valid;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    i_n     = '0;
                    j_n     = '0;
                    lane_n  = '0;
                    round_n = '0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                if (ready) begin
                    if (i_idx != EDGE_IDX) begin
                        i_n    = i_idx + SIZE'(1);
                        lane_n = lane_addr + 5'd1;
                    end else if (j_idx != EDGE_IDX) begin
                        i_n    = '0;
                        j_n    = j_idx + SIZE'(1);
                        lane_n = lane_addr + 5'd1;
                    end else begin
                        i_n    = '0;
                        j_n    = '0;
                        lane_n = '0;
                        if (round_idx != LAST_RND) begin
                            round_n = round_idx + RW'(1);
                        end else begin
                            round_n = '0;
                            state_n = DONE;
                            valid_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            lane_addr <= '0;
            round_idx <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            i_idx     <= i_n;
            j_idx     <= j_n;
            lane_addr <= lane_n;
            round_idx <= round_n;
            valid     <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Boundary flags are decoded from registered state, gated by valid.
    always_comb begin
        last_lane  = valid && (lane_addr == LAST_ADDR);
        last_round = valid && (round_idx == LAST_RND);
    end

endmodule
